// File: rtl/boa_dma_copy.sv
// boa_dma_copy: word-granular memory-to-memory copy engine. It is the initiator
// end of boa_mem_bus and takes bulk copies (e.g. ROM image -> RAM) off the CPU.
//
// Optional feature macro: BOA_DMA_FILL_EN (adds the constant-fill mode).
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_start                  one-cycle request, sampled only while idle
//   i_src, i_dst             byte addresses, bits [1:0] forced to zero
//   i_len                    number of 32-bit words to copy
//   i_fill, i_fill_val       (BOA_DMA_FILL_EN only) fill mode and fill word
//   o_busy                   high from the cycle after start through done
//   o_done                   one-cycle completion pulse
//   o_bus_addr/re/we/wdata   registered bus request
//   i_bus_ready, i_bus_rdata bus response
module boa_dma_copy #(
    parameter int LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [31:0]      i_src,
    input  logic [31:0]      i_dst,
    input  logic [LEN_W-1:0] i_len,
`ifdef BOA_DMA_FILL_EN
    input  logic             i_fill,
    input  logic [31:0]      i_fill_val,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [31:0]      o_bus_addr,
    output logic             o_bus_re,
    output logic [3:0]       o_bus_we,
    output logic [31:0]      o_bus_wdata,
    input  logic             i_bus_ready,
    input  logic [31:0]      i_bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_FIN
    } state_t;

    localparam logic [LEN_W-1:0] L_ONE = LEN_W'(1);

    state_t           r_state;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_rem;
    logic             r_busy;
    logic             r_done;
    logic [31:0]      r_addr;
    logic             r_re;
    logic [3:0]       r_we;
    // Doubles as the data register: the read word is captured straight into
    // the write-data output, so it is already on the bus when WRITE begins.
    logic [31:0]      r_wdata;
`ifdef BOA_DMA_FILL_EN
    logic             r_fill;
`endif

    logic [31:0] w_src_al;
    logic [31:0] w_dst_al;
    logic [31:0] w_dst_nxt;
    logic        w_fill_mode;

    assign w_src_al  = i_src & ~32'd3;
    assign w_dst_al  = i_dst & ~32'd3;
    assign w_dst_nxt = r_dst + 32'd4;

`ifdef BOA_DMA_FILL_EN
    assign w_fill_mode = r_fill;
`else
    assign w_fill_mode = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_re    <= 1'b0;
            r_we    <= 4'h0;
            r_wdata <= '0;
`ifdef BOA_DMA_FILL_EN
            r_fill  <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_src  <= w_src_al;
                        r_dst  <= w_dst_al;
                        r_rem  <= i_len;
                        r_busy <= 1'b1;
`ifdef BOA_DMA_FILL_EN
                        r_fill <= i_fill;
`endif
                        if (i_len == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
`ifdef BOA_DMA_FILL_EN
                        end else if (i_fill) begin
                            r_state <= S_WRITE;
                            r_addr  <= w_dst_al;
                            r_we    <= 4'hF;
                            r_wdata <= i_fill_val;
`endif
                        end else begin
                            r_state <= S_READ;
                            r_addr  <= w_src_al;
                            r_re    <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (i_bus_ready) begin
                        r_wdata <= i_bus_rdata;
                        r_src   <= r_src + 32'd4;
                        r_state <= S_WRITE;
                        r_addr  <= r_dst;
                        r_re    <= 1'b0;
                        r_we    <= 4'hF;
                    end
                end
                S_WRITE: begin
                    if (i_bus_ready) begin
                        r_dst <= w_dst_nxt;
                        r_rem <= r_rem - L_ONE;
                        if (r_rem == L_ONE) begin
                            r_state <= S_FIN;
                            r_we    <= 4'h0;
                            r_done  <= 1'b1;
                        end else if (w_fill_mode) begin
                            // Fill word stays in r_wdata; only the address moves.
                            r_addr <= w_dst_nxt;
                        end else begin
                            r_state <= S_READ;
                            r_we    <= 4'h0;
                            r_re    <= 1'b1;
                            r_addr  <= r_src;
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_bus_addr  = r_addr;
    assign o_bus_re    = r_re;
    assign o_bus_we    = r_we;
    assign o_bus_wdata = r_wdata;

endmodule

// File: tb/tb_boa_dma_copy.sv
// tb_boa_dma_copy: directed bench for boa_dma_copy with a small word memory
// responder (always-ready or ready every third cycle).
module tb_boa_dma_copy;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [31:0] addr;
    logic        re;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
`ifdef BOA_DMA_FILL_EN
    logic        fill;
    logic [31:0] fill_val;
`endif

    always #5 clk = ~clk;

    boa_dma_copy #(.LEN_W(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_src       (src),
        .i_dst       (dst),
        .i_len       (len),
`ifdef BOA_DMA_FILL_EN
        .i_fill      (fill),
        .i_fill_val  (fill_val),
`endif
        .o_busy      (busy),
        .o_done      (done),
        .o_bus_addr  (addr),
        .o_bus_re    (re),
        .o_bus_we    (we),
        .o_bus_wdata (wdata),
        .i_bus_ready (ready),
        .i_bus_rdata (rdata)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:255];
    logic        tb_load;
    logic [7:0]  tb_idx;
    logic [31:0] tb_val;
    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];

    int act_cnt  = 0;
    int re_cnt   = 0;
    int done_cnt = 0;
    int viol     = 0;
    int rdy_mode = 0;
    int rdy_cnt  = 0;
    logic        pend = 1'b0;
    logic [68:0] snap;

    assign rdata = mem[addr[9:2]];

    always @(negedge clk) begin
        rdy_cnt = (rdy_cnt == 2) ? 0 : rdy_cnt + 1;
        ready   = (rdy_mode == 0) || (rdy_cnt == 0);
    end

    always @(posedge clk) begin
        if (tb_load) begin
            mem[tb_idx] <= tb_val;
        end else if (ready && we != 4'h0) begin
            mem[addr[9:2]] <= wdata;
            wr_q.push_back(addr);
        end
        if (ready && re)
            rd_q.push_back(addr);
    end

    always @(posedge clk) begin
        if (re || we != 4'h0) act_cnt++;
        if (re) re_cnt++;
        if (done) done_cnt++;
        if (pend && !rst && {addr, re, we, wdata} !== snap) viol++;
        pend = !rst && (re || we != 4'h0) && !ready;
        snap = {addr, re, we, wdata};
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] idx, input logic [31:0] val);
        tb_load = 1'b1;
        tb_idx  = idx;
        tb_val  = val;
        @(negedge clk);
        tb_load = 1'b0;
    endtask

    task automatic go(input logic [31:0] s, input logic [31:0] d,
                      input logic [15:0] l);
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // k counts cycles after the start edge; exp < 0 skips the latency check.
    task automatic wait_done(input string tag, input int exp, input int limit);
        int k = 1;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_seen"}, 32'(done), 32'd1);
        if (exp >= 0)
            chk({tag, "_lat"}, 32'(k), 32'(exp));
        @(negedge clk);
        chk({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int a0, w0, v0, d0;
        rst     = 1'b1;
        start   = 1'b0;
        src     = '0;
        dst     = '0;
        len     = '0;
        tb_load = 1'b0;
        tb_idx  = '0;
        tb_val  = '0;
`ifdef BOA_DMA_FILL_EN
        fill     = 1'b0;
        fill_val = '0;
`endif

        // reset
        repeat (2) begin
            @(negedge clk);
            chk("rst_ctl", {25'd0, busy, done, re, we}, 32'd0);
            chk("rst_addr", addr, 32'd0);
            chk("rst_wdata", wdata, 32'd0);
        end
        rst = 1'b0;

        // basic copy
        load(8'd64, 32'h11);
        load(8'd65, 32'h22);
        load(8'd66, 32'h33);
        load(8'd67, 32'h44);
        rd_q.delete();
        wr_q.delete();
        go(32'h100, 32'h200, 16'd4);
        chk("t2_busy", 32'(busy), 32'd1);
        wait_done("t2", 9, 50);
        chk("t2_m0", mem[128], 32'h11);
        chk("t2_m1", mem[129], 32'h22);
        chk("t2_m2", mem[130], 32'h33);
        chk("t2_m3", mem[131], 32'h44);
        chk("t2_nwr", 32'(wr_q.size()), 32'd4);
        chk("t2_wr0", wr_q[0], 32'h200);
        chk("t2_rd3", rd_q[3], 32'h10C);

        // zero length
        a0 = act_cnt;
        w0 = wr_q.size();
        go(32'h100, 32'h200, 16'd0);
        wait_done("t3", 1, 10);
        chk("t3_act", 32'(act_cnt - a0), 32'd0);
        chk("t3_nwr", 32'(wr_q.size() - w0), 32'd0);
        chk("t3_mem", mem[128], 32'h11);

        // wait states, ignored start
        load(8'd0, 32'hA5A50001);
        load(8'd1, 32'h5A5A0002);
        rdy_mode = 1;
        rd_q.delete();
        wr_q.delete();
        v0 = viol;
        go(32'h0, 32'h40, 16'd2);
        repeat (3) @(negedge clk);
        go(32'h100, 32'h300, 16'd4);
        wait_done("t4", -1, 200);
        chk("t4_m0", mem[16], 32'hA5A50001);
        chk("t4_m1", mem[17], 32'h5A5A0002);
        chk("t4_stable", 32'(viol - v0), 32'd0);
        chk("t4_nwr", 32'(wr_q.size()), 32'd2);
        repeat (6) @(negedge clk);
        chk("t4_noqueue", {31'd0, busy}, 32'd0);
        chk("t4_nwr2", 32'(wr_q.size()), 32'd2);
        rdy_mode = 0;

        // address wrap, unaligned inputs, overlapping dst
        load(8'd255, 32'hC0DE0001);
        load(8'd0, 32'hC0DE0002);
        rd_q.delete();
        wr_q.delete();
        go(32'hFFFFFFFD, 32'h3, 16'd2);
        wait_done("t5", 5, 20);
        chk("t5_nrd", 32'(rd_q.size()), 32'd2);
        chk("t5_rd0", rd_q[0], 32'hFFFFFFFC);
        chk("t5_rd1", rd_q[1], 32'h0);
        chk("t5_wr0", wr_q[0], 32'h0);
        chk("t5_wr1", wr_q[1], 32'h4);
        chk("t5_m0", mem[0], 32'hC0DE0001);
        chk("t5_m1", mem[1], 32'hC0DE0001);

        // reset mid-transfer
        load(8'd192, 32'd1);
        load(8'd193, 32'd2);
        load(8'd194, 32'd3);
        load(8'd195, 32'd4);
        load(8'd240, 32'd0);
        go(32'h300, 32'h380, 16'd4);
        repeat (3) @(negedge clk);
        chk("t6_waddr", addr, 32'h384);
        chk("t6_we", {28'd0, we}, 32'hF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_ctl", {25'd0, busy, done, re, we}, 32'd0);
        chk("t6_addr", addr, 32'd0);
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        chk("t6_nodone", 32'(done_cnt - d0), 32'd0);
        go(32'h300, 32'h3C0, 16'd1);
        wait_done("t6", 3, 20);
        chk("t6_m", mem[240], 32'd1);

`ifdef BOA_DMA_FILL_EN
        // constant fill
        fill     = 1'b1;
        fill_val = 32'hDEADBEEF;
        a0       = re_cnt;
        go(32'h0, 32'h80, 16'd3);
        wait_done("fill", 4, 20);
        chk("fill_m0", mem[32], 32'hDEADBEEF);
        chk("fill_m1", mem[33], 32'hDEADBEEF);
        chk("fill_m2", mem[34], 32'hDEADBEEF);
        chk("fill_re", 32'(re_cnt - a0), 32'd0);
        fill = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
